// File: rtl/z80_int_pkg.sv
// Shared types and helpers for the Z80 mode-2 interrupt controller.
package z80_int_pkg;

   localparam int unsigned VEC_W      = 8;
   localparam int unsigned PRIO_MAX_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } int_state_e;

   // One-hot of the lowest set bit (index 0 = highest priority).
   function automatic logic [PRIO_MAX_W-1:0] prio_first(input logic [PRIO_MAX_W-1:0] v);
      return v & (~v + PRIO_MAX_W'(1));
   endfunction

endpackage

// File: rtl/z80_int_if.sv
// CPU-side bus, source lines and status outputs of the interrupt controller.
interface z80_int_if
   import z80_int_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4
);
   logic               cen;
   logic [NUM_SRC-1:0] src;
   logic               mask_we;
   logic [NUM_SRC-1:0] mask_din;
   logic [NUM_SRC-1:0] ack_clr;
   logic               m1_n;
   logic               iorq_n;
   logic               reti;
   logic               iei;
   logic               ieo;
   logic               int_n;
   logic               vec_oe;
   logic [VEC_W-1:0]   vec_out;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] in_service;

   modport master (
      output cen, src, mask_we, mask_din, ack_clr, m1_n, iorq_n, reti, iei,
      input  ieo, int_n, vec_oe, vec_out, pending, in_service
   );

   modport slave (
      input  cen, src, mask_we, mask_din, ack_clr, m1_n, iorq_n, reti, iei,
      output ieo, int_n, vec_oe, vec_out, pending, in_service
   );
endinterface

// File: rtl/z80_int_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, reported as one-hot and index.
module z80_int_prio_enc
   import z80_int_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]     req_i,
   output logic [W-1:0]     onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   assign onehot_o = W'(prio_first(PRIO_MAX_W'(req_i)));
   assign valid_o  = |req_i;

   // Scan from the bottom of the priority order so the lowest index lands last.
   always_comb begin
      idx_o = '0;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 mode-2 interrupt controller with mask, fixed priority and daisy chain.
// Define Z80_INT_NESTED_EN to let higher-priority sources interrupt a running ISR.
module z80_int_ctrl
   import z80_int_pkg::*;
#(
   parameter int unsigned        NUM_SRC   = 4,
   parameter logic [VEC_W-1:0]   VEC_BASE  = 8'h08,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}}
) (
   input logic     clk_sys,
   input logic     reset,
   z80_int_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   int_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] insvc_q, insvc_d;
   logic [NUM_SRC-1:0] hist_q;
   logic [NUM_SRC-1:0] sup_q, sup_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic               vec_oe_q, vec_oe_d;
   logic               int_n_q, int_n_d;

   logic               inta_c;
   logic               accept;
   logic [NUM_SRC-1:0] isv_oh, elig, win_oh, acc_oh, edge_set, reti_clr;
   logic [IDX_W-1:0]   win_idx, isv_idx_unused;
   logic               isv_valid, win_valid;

   assign inta_c = ~bus.m1_n & ~bus.iorq_n;

   z80_int_prio_enc #(.W(NUM_SRC), .IDX_W(IDX_W)) u_isv_enc (
      .req_i    (insvc_q),
      .onehot_o (isv_oh),
      .idx_o    (isv_idx_unused),
      .valid_o  (isv_valid)
   );

   // Sources allowed to compete given what is already in service.
`ifdef Z80_INT_NESTED_EN
   assign elig = isv_valid ? (isv_oh - NUM_SRC'(1)) : '1;
`else
   assign elig = isv_valid ? '0 : '1;
`endif

   z80_int_prio_enc #(.W(NUM_SRC), .IDX_W(IDX_W)) u_win_enc (
      .req_i    (pend_q & elig),
      .onehot_o (win_oh),
      .idx_o    (win_idx),
      .valid_o  (win_valid)
   );

   // Acknowledge state machine: latch vector on INTA, hold until INTA ends.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      vec_oe_d = vec_oe_q;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (inta_c) begin
               state_d  = ACK;
               vec_oe_d = 1'b0;
               if (bus.iei && win_valid) begin
                  accept   = 1'b1;
                  vec_oe_d = 1'b1;
                  vec_d    = {VEC_BASE[VEC_W-1:1] + (VEC_W-1)'(win_idx), 1'b0};
               end
            end
         end
         ACK: begin
            if (!inta_c) begin
               vec_oe_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pending / in-service / level-suppress next state.
   always_comb begin
      acc_oh   = accept ? win_oh : '0;
      mask_d   = bus.mask_we ? bus.mask_din : mask_q;
      edge_set = EDGE_MASK & bus.src & ~hist_q & ~mask_d;
      sup_d    = ~EDGE_MASK & ((sup_q & bus.src) | acc_oh);
      pend_d   = (EDGE_MASK & (edge_set | (pend_q & ~bus.ack_clr & ~acc_oh)))
               | (~EDGE_MASK & bus.src & ~mask_d & ~sup_d);
      reti_clr = bus.reti ? isv_oh : '0;
      insvc_d  = (insvc_q & ~reti_clr) | acc_oh;
      int_n_d  = ~(bus.iei & win_valid);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else if (bus.cen) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mask_q   <= '1;
         pend_q   <= '0;
         insvc_q  <= '0;
         hist_q   <= '0;
         sup_q    <= '0;
         vec_q    <= '0;
         vec_oe_q <= 1'b0;
         int_n_q  <= 1'b1;
      end else if (bus.cen) begin
         mask_q   <= mask_d;
         pend_q   <= pend_d;
         insvc_q  <= insvc_d;
         hist_q   <= bus.src;
         sup_q    <= sup_d;
         vec_q    <= vec_d;
         vec_oe_q <= vec_oe_d;
         int_n_q  <= int_n_d;
      end
   end

   assign bus.int_n      = int_n_q;
   assign bus.vec_oe     = vec_oe_q;
   assign bus.vec_out    = vec_q;
   assign bus.pending    = pend_q;
   assign bus.in_service = insvc_q;
   assign bus.ieo        = bus.iei & ~(|insvc_q);

endmodule

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
Parametrised Z80 mode-2 interrupt controller. It replaces the ad-hoc keyboard/CTC interrupt logic and vector mux in the machine top level. It handles NUM_SRC edge- or level-triggered sources, with per-source mask and fixed priority, and drives the vector during INTA. It takes part in the daisy chain via iei/ieo (CTC fed from ieo) and releases the in-service state on RETI from z80reti.

Parameters:
NUM_SRC, 4, number of interrupt sources; index 0 = highest priority
VEC_BASE, 8'h08, vector of source i = VEC_BASE + 2*i (mod 256, bit 0 always 0)
EDGE_MASK, 4'b1111, bit i = 1: source i rising-edge triggered; 0: level triggered (high = request)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
cen  in  1  CPU clock enable; all state updates only when cen = 1
src  in  NUM_SRC  raw request lines, active high, synchronous to clk_sys
mask_we  in  1  write strobe for mask register
mask_din  in  NUM_SRC  new mask; 1 = masked
ack_clr  in  NUM_SRC  per-source pending clear (e.g. status-port read)
m1_n  in  1  CPU M1
iorq_n  in  1  CPU IORQ
reti  in  1  one-cen-cycle RETI strobe from z80reti
iei  in  1  daisy-chain enable in
ieo  out  1  daisy-chain enable out
int_n  out  1  interrupt request to CPU, active low
vec_oe  out  1  vector valid on bus
vec_out  out  8  vector
pending  out  NUM_SRC  pending register (status read)
in_service  out  NUM_SRC  in-service register

Behaviour:
- Reset: mask = all 1, pending = 0, in_service = 0, edge history = 0, FSM = IDLE, int_n = 1, vec_oe = 0, vec_out = 8'h00, ieo = iei.
- Edge source: pending[i] is set on the cen cycle where src[i] = 1, hist[i] = 0 and mask[i] = 0. hist updates every cen cycle, whether or not the source is masked.
- Level source: pending[i] = src[i] & ~mask[i], re-evaluated every cen cycle.
- Clearing pending[i]: ack_clr[i] (edge sources only), or INTA acceptance of source i.
- Same cycle set and ack_clr: set wins.
- Same cycle mask_we and edge: the new mask is used.
- Masking a source does not clear an already-pending edge source.
- Winner: lowest-index pending source whose index is higher priority than every in-service bit (see Optional Feature).
- int_n: 0 when iei = 1 and a winner exists; registered, 1 cen cycle latency from the pending update.
- ieo = iei & ~|in_service. Combinational.
- inta = ~m1_n & ~iorq_n.
- FSM:
  - IDLE: if inta, iei = 1 and a winner exists, latch the winner index, set vec_out = VEC_BASE + 2*idx, vec_oe = 1, set in_service[idx], clear pending[idx] (level source: suppressed until it falls, then re-arms), go to ACK. If inta with no winner or iei = 0, go to ACK with vec_oe = 0.
  - ACK: hold vec_out/vec_oe while inta is true. When inta is false: vec_oe = 0, go to IDLE.
- RETI: clears the highest-priority set in_service bit. No effect if none is set. If RETI coincides with INTA acceptance, the clear applies first, then the new set.
- Reset mid-INTA: asynchronous return to the reset state; vec_oe falls immediately.

Optional Feature:
Macro: Z80_INT_NESTED_EN.
- Defined: nesting allowed. A pending source with index lower than the lowest set in_service bit may interrupt, so in_service can hold multiple bits.
- Undefined: any set in_service bit blocks all requests (int_n = 1), so at most one bit is set.
- ieo is identical in both builds.

Decomposition:
- Package z80_int_pkg: FSM state enum (IDLE, ACK), localparam VEC_W = 8, function prio_first(vector) returning one-hot lowest set bit.
- Sub-module z80_int_prio_enc: parametrised priority encoder (one-hot + index + valid), used for both winner selection and RETI clear.

Test Plan:
- Reset, mask_din = 4'b0000, src[2] rising edge -> int_n = 0 after 1 cen cycle; INTA -> vec_oe = 1, vec_out = 8'h0C, in_service = 4'b0100, pending[2] = 0.
- src[3] and src[1] edges in the same cycle, INTA -> vec_out = 8'h0A first; RETI -> int_n = 0 again; second INTA -> vec_out = 8'h0E.
- In-service 2, then src[0] edge: nested build gives int_n = 0 and vec_out = 8'h08; non-nested build keeps int_n = 1 until RETI.
- src[1] edge while mask[1] = 1 -> no pending; later unmask -> still no pending. Edge with iei = 0 -> pending = 1, int_n = 1, ieo = 0.
- ack_clr[0] in the same cycle as a src[0] edge -> pending[0] stays 1. Level source 1 held high after INTA -> no re-request until it drops and rises again.
- Reset asserted during ACK -> vec_oe = 0 and in_service = 0 immediately, int_n = 1.
